counter_checker: RTL and testbench
==================================

Name: counter_checker

Overview:
- Sink-side companion to the free-running 4-bit `counter`. It samples a counter's `result` bus and checks that each sample is the previous value +1, modulo 2^WIDTH.
- Reports lock status, mismatch pulses, a saturating error count and a wrap count.
- Sits beside any `counter` instance in the bench or the fabric; samples are qualified by `count_valid`, so it can watch a counter running on a slower enable.

Parameters:
- WIDTH, 4, width of the observed count bus.
- LOCK_LEN, 2, consecutive correct increments required to declare lock (1 or more).
- ERR_CNT_W, 8, width of the saturating error counter.
- WRAP_CNT_W, 8, width of the saturating wrap counter.
- ALLOW_HOLD, 1, when 1 a sample equal to the previous value is a stall and is ignored; when 0 it is a mismatch.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- count_in  in  WIDTH  observed counter value.
- count_valid  in  1  count_in is sampled on this edge when high.
- locked  out  1  checker is tracking a correctly incrementing sequence.
- err  out  1  one-cycle pulse on a mismatch while locked.
- err_cnt  out  ERR_CNT_W  number of mismatches seen while locked; saturates at all-ones.
- wrap_cnt  out  WRAP_CNT_W  number of max-to-0 transitions seen while locked; saturates at all-ones.
- last_value  out  WIDTH  most recently accepted sample.

Behaviour:
- **Reset.** reset=0 at a clk edge forces:
  - state=IDLE, run=0;
  - locked=0, err=0, err_cnt=0, wrap_cnt=0, last_value=0.
  - Reset mid-operation discards lock and all counts.
- **Outputs.** All outputs are registered. A sample taken at edge N is reflected in the outputs after edge N. err is high for exactly that one cycle.
- **Definitions.**
  - expected = last_value + 1, truncated to WIDTH bits, so max wraps to 0.
  - run is an internal counter, sized to hold LOCK_LEN.
- **count_valid=0.** No state change, and err deasserts.
- **States:**
  - IDLE: on valid → last_value<=count_in, run<=0, go to ACQUIRE. No check is performed.
  - ACQUIRE, valid and count_in==expected: last_value<=count_in, run<=run+1. If run+1==LOCK_LEN → LOCKED and locked<=1.
  - ACQUIRE, valid and hold (count_in==last_value, ALLOW_HOLD=1): ignored, nothing changes.
  - ACQUIRE, valid and any other value: last_value<=count_in, run<=0, stay in ACQUIRE. No err; errors count only while locked.
  - LOCKED, valid and match: last_value<=count_in. If count_in==0, wrap_cnt increments (saturating).
  - LOCKED, valid and hold with ALLOW_HOLD=1: ignored.
  - LOCKED, valid and mismatch: err<=1, err_cnt increments (saturating), locked<=0, run<=0, last_value<=count_in, go to ACQUIRE.
- **Boundaries.**
  - With LOCK_LEN=1, one correct increment locks.
  - Saturated counters hold at all-ones.
  - The first sample after IDLE is never an error.
  - A hold with ALLOW_HOLD=0 is a mismatch.

Optional Feature:
- Macro: CHK_STICKY_FAULT_EN.
- With the macro defined:
  - A mismatch in LOCKED goes to a FAULT state instead of ACQUIRE.
  - FAULT ignores all samples and keeps last_value frozen at the offending sample.
  - Output `fault` (1 bit) is 1 in FAULT; err still pulses once.
  - Only reset leaves FAULT.
- Without the macro: there is no FAULT state and no `fault` port; behaviour is as above.

Decomposition:
- Shared package `counter_pkg`:
  - state enum (IDLE, ACQUIRE, LOCKED, FAULT);
  - a saturating-increment function;
  - default WIDTH constant shared with `counter`.
- One natural sub-module, `sat_counter` (parameter W; inc input; count output; synchronous active-low reset), instantiated for err_cnt and wrap_cnt.

Test Plan:
- Reset held low for 10 cycles with count_valid toggling → all outputs 0, locked=0.
- Defaults; valid each cycle; feed 0,1,2,3 → locked=1 after the edge sampling 2. Continue 4..15,0 → wrap_cnt=1, err never high.
- Locked; feed 5 then 9 → err high for exactly one cycle, err_cnt=1, locked=0, last_value=9. Then 10,11 → locked=1 again.
- Locked at 7; ALLOW_HOLD=1; feed 7,7,8 → no err, last_value=8. Rebuild with ALLOW_HOLD=0 → the first repeated 7 gives err=1.
- ERR_CNT_W=2; force 5 mismatches, each followed by relock → err_cnt stops at 3. Mid-sequence reset → all counts 0, state IDLE.
- CHK_STICKY_FAULT_EN defined; locked; feed 3 then 6 → fault=1, err one pulse. Further 7,8 are ignored and last_value stays 6. Reset clears fault.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the free-running counter and its sink-side checker.
package counter_pkg;

    localparam int COUNTER_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } chk_state_e;

    // +1 that sticks at the all-ones value of a `width`-bit field (width 1..32).
    function automatic logic [31:0] satInc(input logic [31:0] value, input int width);
        logic [31:0] maxVal;
        maxVal = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= maxVal) ? maxVal : value + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous active-low reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    import counter_pkg::*;

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = W'(satInc(32'(count_q), W));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_checker.sv
// Checks that a sampled counter bus increments by one per valid sample.
// Define CHK_STICKY_FAULT_EN to make a locked-state mismatch latch a FAULT state.
module counter_checker
    import counter_pkg::*;
#(
    parameter int WIDTH      = COUNTER_WIDTH,
    parameter int LOCK_LEN   = 2,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 8,
    parameter int ALLOW_HOLD = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  count_valid,
    output logic                  locked,
    output logic                  err,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [WRAP_CNT_W-1:0] wrap_cnt,
    output logic [WIDTH-1:0]      last_value
`ifdef CHK_STICKY_FAULT_EN
    ,
    output logic                  fault
`endif
);

    localparam int RUN_W = $clog2(LOCK_LEN + 1);

    chk_state_e       state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, runInc;
    logic [WIDTH-1:0] lastValue_q, lastValue_d, expected;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             errInc, wrapInc;
    logic             isMatch, isHold;

    assign expected = lastValue_q + WIDTH'(1);
    assign isMatch  = (count_in == expected);
    assign isHold   = (ALLOW_HOLD != 0) && (count_in == lastValue_q);
    assign runInc   = run_q + RUN_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            run_q       <= '0;
            lastValue_q <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            lastValue_q <= lastValue_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (count_valid) begin
            case (state_q)
                IDLE:    state_d = ACQUIRE;
                ACQUIRE: if (isMatch && runInc == RUN_W'(LOCK_LEN)) state_d = LOCKED;
                LOCKED: begin
                    if (!isMatch && !isHold) begin
`ifdef CHK_STICKY_FAULT_EN
                        state_d = FAULT;
`else
                        state_d = ACQUIRE;
`endif
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // A hold (when allowed) falls through every branch and changes nothing.
    always_comb begin
        run_d       = run_q;
        lastValue_d = lastValue_q;
        err_d       = 1'b0;
        errInc      = 1'b0;
        wrapInc     = 1'b0;
        if (count_valid) begin
            case (state_q)
                IDLE: begin
                    lastValue_d = count_in;
                    run_d       = '0;
                end
                ACQUIRE: begin
                    if (isMatch) begin
                        lastValue_d = count_in;
                        run_d       = runInc;
                    end else if (!isHold) begin
                        lastValue_d = count_in;
                        run_d       = '0;
                    end
                end
                LOCKED: begin
                    if (isMatch) begin
                        lastValue_d = count_in;
                        wrapInc     = (count_in == '0);
                    end else if (!isHold) begin
                        err_d       = 1'b1;
                        errInc      = 1'b1;
                        run_d       = '0;
                        lastValue_d = count_in;
                    end
                end
                default: begin
                    run_d = run_q;
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    sat_counter #(.W(ERR_CNT_W)) errCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (errInc),
        .count (err_cnt)
    );

    sat_counter #(.W(WRAP_CNT_W)) wrapCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (wrapInc),
        .count (wrap_cnt)
    );

    assign locked     = locked_q;
    assign err        = err_q;
    assign last_value = lastValue_q;
`ifdef CHK_STICKY_FAULT_EN
    assign fault      = (state_q == FAULT);
`endif

endmodule

// File: tb/tb_counter_checker.sv
// Randomized bench for counter_checker: a default instance and a LOCK_LEN=1,
// ALLOW_HOLD=0, ERR_CNT_W=2 instance share stimulus and are scored against a model.
module tb_counter_checker;

    logic       clk;
    logic       reset;
    logic [3:0] count_in;
    logic       count_valid;

    logic       locked0, err0, locked1, err1;
    logic [7:0] errCnt0, wrapCnt0, wrapCnt1;
    logic [1:0] errCnt1;
    logic [3:0] last0, last1;
`ifdef CHK_STICKY_FAULT_EN
    logic       fault0, fault1;
`endif

    int checks = 0;
    int errors = 0;

    int pLockLen[2] = '{2, 1};
    int pHold[2]    = '{1, 0};
    int pErrMax[2]  = '{255, 3};
    int pWrapMax[2] = '{255, 255};

    int mSeen[2], mLocked[2], mStreak[2], mLast[2];
    int mErr[2], mErrCnt[2], mWrap[2], mFault[2];

    counter_checker dut0 (
        .clk         (clk),
        .reset       (reset),
        .count_in    (count_in),
        .count_valid (count_valid),
        .locked      (locked0),
        .err         (err0),
        .err_cnt     (errCnt0),
        .wrap_cnt    (wrapCnt0),
        .last_value  (last0)
`ifdef CHK_STICKY_FAULT_EN
        ,
        .fault       (fault0)
`endif
    );

    counter_checker #(.LOCK_LEN(1), .ERR_CNT_W(2), .ALLOW_HOLD(0)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .count_in    (count_in),
        .count_valid (count_valid),
        .locked      (locked1),
        .err         (err1),
        .err_cnt     (errCnt1),
        .wrap_cnt    (wrapCnt1),
        .last_value  (last1)
`ifdef CHK_STICKY_FAULT_EN
        ,
        .fault       (fault1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Reference behaviour: track the last accepted sample and a streak of correct +1 steps.
    task automatic modelStep(input int rst, input int v, input int x);
        for (int i = 0; i < 2; i++) begin
            mErr[i] = 0;
            if (rst == 0) begin
                mSeen[i] = 0; mLocked[i] = 0; mStreak[i] = 0; mLast[i] = 0;
                mErrCnt[i] = 0; mWrap[i] = 0; mFault[i] = 0;
            end else if (v != 0 && mFault[i] == 0) begin
                if (mSeen[i] == 0) begin
                    mSeen[i] = 1; mLast[i] = x; mStreak[i] = 0;
                end else if (x == (mLast[i] + 1) % 16) begin
                    mLast[i] = x;
                    if (mLocked[i] != 0) begin
                        if (x == 0 && mWrap[i] < pWrapMax[i]) mWrap[i]++;
                    end else begin
                        mStreak[i]++;
                        if (mStreak[i] == pLockLen[i]) mLocked[i] = 1;
                    end
                end else if (!(pHold[i] != 0 && x == mLast[i])) begin
                    if (mLocked[i] != 0) begin
                        mErr[i] = 1;
                        if (mErrCnt[i] < pErrMax[i]) mErrCnt[i]++;
                        mLocked[i] = 0;
`ifdef CHK_STICKY_FAULT_EN
                        mFault[i] = 1;
`endif
                    end
                    mLast[i] = x;
                    mStreak[i] = 0;
                end
            end
        end
    endtask

    task automatic compareModel();
        checkOutput("dut0.locked", int'(locked0), mLocked[0]);
        checkOutput("dut0.err", int'(err0), mErr[0]);
        checkOutput("dut0.err_cnt", int'(errCnt0), mErrCnt[0]);
        checkOutput("dut0.wrap_cnt", int'(wrapCnt0), mWrap[0]);
        checkOutput("dut0.last_value", int'(last0), mLast[0]);
        checkOutput("dut1.locked", int'(locked1), mLocked[1]);
        checkOutput("dut1.err", int'(err1), mErr[1]);
        checkOutput("dut1.err_cnt", int'(errCnt1), mErrCnt[1]);
        checkOutput("dut1.wrap_cnt", int'(wrapCnt1), mWrap[1]);
        checkOutput("dut1.last_value", int'(last1), mLast[1]);
`ifdef CHK_STICKY_FAULT_EN
        checkOutput("dut0.fault", int'(fault0), mFault[0]);
        checkOutput("dut1.fault", int'(fault1), mFault[1]);
`endif
    endtask

    task automatic applyStimulus(input logic rst, input logic v, input logic [3:0] x);
        @(negedge clk);
        reset       = rst;
        count_valid = v;
        count_in    = x;
        @(posedge clk);
        modelStep(int'(rst), int'(v), int'(x));
        #1;
        compareModel();
    endtask

    initial begin
        int gen;
        reset       = 1'b0;
        count_valid = 1'b0;
        count_in    = 4'd0;

        for (int n = 0; n < 10; n++) applyStimulus(1'b0, n[0], 4'(n));
        checkOutput("rst.locked", int'(locked0), 0);
        checkOutput("rst.err_cnt", int'(errCnt0), 0);
        checkOutput("rst.wrap_cnt", int'(wrapCnt0), 0);
        checkOutput("rst.last_value", int'(last0), 0);

        for (int n = 0; n <= 2; n++) applyStimulus(1'b1, 1'b1, 4'(n));
        checkOutput("dir.lockAfter2", int'(locked0), 1);
        for (int n = 3; n <= 16; n++) applyStimulus(1'b1, 1'b1, 4'(n % 16));
        checkOutput("dir.wrap0", int'(wrapCnt0), 1);
        checkOutput("dir.wrap1", int'(wrapCnt1), 1);

        for (int n = 1; n <= 5; n++) applyStimulus(1'b1, 1'b1, 4'(n));
        applyStimulus(1'b1, 1'b1, 4'd9);
        checkOutput("dir.errPulse", int'(err0), 1);
        checkOutput("dir.errCnt", int'(errCnt0), 1);
        checkOutput("dir.unlock", int'(locked0), 0);
        checkOutput("dir.lastBad", int'(last0), 9);
        applyStimulus(1'b1, 1'b1, 4'd10);
        checkOutput("dir.errOneCycle", int'(err0), 0);
        applyStimulus(1'b1, 1'b1, 4'd11);

        applyStimulus(1'b0, 1'b1, 4'd3);
        for (int n = 5; n <= 7; n++) applyStimulus(1'b1, 1'b1, 4'(n));
        applyStimulus(1'b1, 1'b1, 4'd7);
        checkOutput("dir.holdOk", int'(err0), 0);
        checkOutput("dir.holdErr", int'(err1), 1);
        applyStimulus(1'b1, 1'b1, 4'd7);
        applyStimulus(1'b1, 1'b1, 4'd8);
        checkOutput("dir.holdLast", int'(last0), 8);
        checkOutput("dir.holdErrCnt", int'(errCnt0), 0);

        gen = 8;
        for (int n = 0; n < 2500; n++) begin
            logic rst, v;
            int r;
            rst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            v   = ($urandom_range(0, 9) < 8);
            r   = $urandom_range(0, 99);
            if (v) begin
                if (r < 78) gen = (gen + 1) % 16;
                else if (r >= 88) gen = $urandom_range(0, 15);
            end
            applyStimulus(rst, v, gen[3:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
